// File: rtl/result_matrix_collector.sv
// Result matrix store behind the sequential multiplier: accepts (i,j,value) writes with a one-cycle ack,
// serves combinational readback for accumulation, then drains row-major over valid/ready (stalls hold data).
module result_matrix_collector #(
  parameter int m     = 4,
  parameter int m_len = $clog2(m),
  parameter int W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [W-1:0]     z_out,
  input  logic [m_len-1:0] z_i,
  input  logic [m_len-1:0] z_j,
  input  logic             z_stb,
  output logic             z_ack,
  output logic [W-1:0]     current_element,
  input  logic             done,
  output logic [W-1:0]     out_data,
  output logic [m_len-1:0] out_i,
  output logic [m_len-1:0] out_j,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             out_done,
  output logic             err
);

  typedef enum logic [2:0] {IDLE, CLEAR, COLLECT, DRAIN, FINISHED} state_t;

  localparam logic [m_len-1:0] LAST_IDX = m_len'(m - 1);
  localparam logic [m_len:0]   M_EXT    = (m_len + 1)'(m);

  state_t           state_q, state_d;
  logic [W-1:0]     mem_q [m][m];
  logic             z_ack_q, z_ack_d;
  logic             err_q, err_d;
  logic             out_done_q, out_done_d;
  logic [m_len-1:0] out_i_q, out_i_d;
  logic [m_len-1:0] out_j_q, out_j_d;
  logic             mem_wr, mem_clr;
  logic             z_in_range;
  logic             drain_last;

  assign z_in_range = ({1'b0, z_i} < M_EXT) && ({1'b0, z_j} < M_EXT);
  assign drain_last = (out_i_q == LAST_IDX) && (out_j_q == LAST_IDX);

  assign z_ack           = z_ack_q;
  assign err             = err_q;
  assign out_done        = out_done_q;
  assign out_i           = out_i_q;
  assign out_j           = out_j_q;
  assign out_valid       = (state_q == DRAIN);
  assign out_last        = out_valid && drain_last;
  assign out_data        = mem_q[out_i_q][out_j_q];
  // No write bypass: a value written on an edge is readable from the next cycle.
  assign current_element = z_in_range ? mem_q[z_i][z_j] : '0;

  always_comb begin
    state_d    = state_q;
    z_ack_d    = 1'b0;
    err_d      = err_q;
    out_done_d = out_done_q;
    out_i_d    = out_i_q;
    out_j_d    = out_j_q;
    mem_wr     = 1'b0;
    mem_clr    = 1'b0;
    case (state_q)
      IDLE, FINISHED: begin
        if (z_stb) err_d = 1'b1;
        if (start) state_d = CLEAR;
      end
      CLEAR: begin
        mem_clr    = 1'b1;
        err_d      = 1'b0;
        out_done_d = 1'b0;
        out_i_d    = '0;
        out_j_d    = '0;
        state_d    = COLLECT;
      end
      COLLECT: begin
        // A pending write always wins over done; the move to DRAIN waits for a quiet handshake.
        if (z_stb && !z_ack_q) begin
          z_ack_d = 1'b1;
          if (z_in_range) mem_wr = 1'b1;
          else            err_d  = 1'b1;
        end else if (done && !z_stb && !z_ack_q) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (z_stb) err_d = 1'b1;
        if (out_ready) begin
          if (drain_last) begin
            state_d    = FINISHED;
            out_done_d = 1'b1;
            out_i_d    = '0;
            out_j_d    = '0;
          end else if (out_j_q == LAST_IDX) begin
            out_j_d = '0;
            out_i_d = out_i_q + 1'b1;
          end else begin
            out_j_d = out_j_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      z_ack_q    <= 1'b0;
      err_q      <= 1'b0;
      out_done_q <= 1'b0;
      out_i_q    <= '0;
      out_j_q    <= '0;
      for (int r = 0; r < m; r++)
        for (int c = 0; c < m; c++)
          mem_q[r][c] <= '0;
    end else begin
      state_q    <= state_d;
      z_ack_q    <= z_ack_d;
      err_q      <= err_d;
      out_done_q <= out_done_d;
      out_i_q    <= out_i_d;
      out_j_q    <= out_j_d;
      if (mem_clr) begin
        for (int r = 0; r < m; r++)
          for (int c = 0; c < m; c++)
            mem_q[r][c] <= '0;
      end else if (mem_wr) begin
        mem_q[z_i][z_j] <= z_out;
      end
    end
  end

endmodule

// File: tb/tb_result_matrix_collector.sv
// Directed bench for result_matrix_collector with a queue-based drain scoreboard.
module tb_result_matrix_collector;

  localparam int M  = 4;
  localparam int ML = 2;
  localparam int W  = 32;

  logic          clk = 1'b0;
  logic          rst, start, z_stb, done, out_ready;
  logic [W-1:0]  z_out;
  logic [ML-1:0] z_i, z_j;
  logic          z_ack, out_valid, out_last, out_done, err;
  logic [W-1:0]  current_element, out_data;
  logic [ML-1:0] out_i, out_j;

  result_matrix_collector #(.m(M), .m_len(ML), .W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .z_out(z_out), .z_i(z_i), .z_j(z_j),
    .z_stb(z_stb), .z_ack(z_ack), .current_element(current_element), .done(done),
    .out_data(out_data), .out_i(out_i), .out_j(out_j), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .out_done(out_done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0]  d;
    logic [ML-1:0] i;
    logic [ML-1:0] j;
    logic          last;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] model [M][M];
  int           checks  = 0;
  int           errors  = 0;
  int           xfer_cnt = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic model_clear();
    for (int r = 0; r < M; r++)
      for (int c = 0; c < M; c++)
        model[r][c] = '0;
  endtask

  task automatic push_drain();
    exp_t e;
    for (int k = 0; k < M * M; k++) begin
      e.d    = model[k / M][k % M];
      e.i    = ML'(k / M);
      e.j    = ML'(k % M);
      e.last = (k == M * M - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic write_elem(input int i, input int j, input logic [W-1:0] v);
    int n;
    z_i = ML'(i); z_j = ML'(j); z_out = v; z_stb = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!z_ack && n < 8);
    chk("write_ack", z_ack, 1);
    z_stb = 1'b0;
    model[i][j] = v;
    tick();
    chk("write_ack_drop", z_ack, 0);
  endtask

  task automatic wait_done(input int lim);
    int n;
    n = 0;
    while (!out_done && n < lim) begin tick(); n++; end
    chk("drain_done", out_done, 1);
    chk("drain_count", xfer_cnt, M * M);
    chk("drain_queue_empty", exp_q.size(), 0);
    chk("valid_after_drain", out_valid, 0);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    tick();
    start = 1'b0;
    model_clear();
  endtask

  // Scoreboard monitor: every accepted drain beat is popped and compared.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      xfer_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL drain_extra: got %h at (%0d,%0d) expected no transfer", out_data, out_i, out_j);
      end else begin
        e = exp_q.pop_front();
        if (out_data !== e.d || out_i !== e.i || out_j !== e.j || out_last !== e.last) begin
          errors++;
          $display("FAIL drain_beat: got d=%h i=%0d j=%0d last=%b expected d=%h i=%0d j=%0d last=%b",
                   out_data, out_i, out_j, out_last, e.d, e.i, e.j, e.last);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    logic [ML*2-1:0] pat;
    logic            prev_stall;
    logic [W-1:0]    prev_d;
    logic [ML-1:0]   prev_i, prev_j;
    int              nz, n;

    rst = 1'b1; start = 1'b0; z_stb = 1'b0; done = 1'b0; out_ready = 1'b0;
    z_out = '0; z_i = '0; z_j = '0;
    model_clear();
    tick(); tick(); tick();
    rst = 1'b0;
    chk("rst_valid", out_valid, 0);
    chk("rst_ack", z_ack, 0);
    chk("rst_done", out_done, 0);
    chk("rst_err", err, 0);
    chk("rst_last", out_last, 0);
    chk("rst_oi", out_i, 0);
    chk("rst_oj", out_j, 0);
    chk("rst_ce", current_element, 0);

    // Collection 1: start held high into COLLECT, values i*4+j+1, full-speed drain.
    start = 1'b1;
    tick(); tick();
    for (int i = 0; i < M; i++)
      for (int j = 0; j < M; j++) begin
        write_elem(i, j, W'(i * M + j + 1));
        start = 1'b0;
      end
    chk("collect_err", err, 0);
    push_drain();
    xfer_cnt = 0;
    done = 1'b1; out_ready = 1'b1;
    tick();
    chk("first_valid_latency", out_valid, 1);
    done = 1'b0;
    wait_done(40);

    // Strobe in FINISHED flags err without ack; restart clears err, out_done and mem.
    out_ready = 1'b0;
    z_i = 2'd1; z_j = 2'd2; z_stb = 1'b1;
    tick();
    chk("finished_stb_ack", z_ack, 0);
    chk("finished_stb_err", err, 1);
    chk("finished_ce_before_clear", current_element, 7);
    z_stb = 1'b0;
    do_start();
    chk("restart_err", err, 0);
    chk("restart_done", out_done, 0);
    chk("restart_mem", current_element, 0);

    // Accumulate readback with no bypass.
    write_elem(2, 1, 32'h3F80_0000);
    chk("readback", current_element, 32'h3F80_0000);
    z_out = 32'h4000_0000; z_stb = 1'b1;
    #1;
    chk("no_bypass", current_element, 32'h3F80_0000);
    tick();
    chk("overwrite_ack", z_ack, 1);
    chk("overwrite_visible", current_element, 32'h4000_0000);
    z_stb = 1'b0;
    model[2][1] = 32'h4000_0000;
    tick();

    // Held strobe on (0,0): ack 1,0,1,0,1,0; z_out changes every cycle.
    z_i = 2'd0; z_j = 2'd0; z_stb = 1'b1;
    for (int k = 0; k < 6; k++) begin
      z_out = 32'hA0 + W'(k);
      tick();
      chk("held_ack", z_ack, (k % 2 == 0) ? 1 : 0);
    end
    z_stb = 1'b0;
    model[0][0] = 32'hA4;
    chk("held_final", current_element, 32'hA4);

    // done coincident with an unacked strobe: write lands first, then DRAIN.
    model[3][3] = 32'h0000_DEAD;
    push_drain();
    xfer_cnt = 0;
    z_i = 2'd3; z_j = 2'd3; z_out = 32'h0000_DEAD; z_stb = 1'b1; done = 1'b1;
    tick();
    chk("coincide_ack", z_ack, 1);
    chk("coincide_not_drain", out_valid, 0);
    z_stb = 1'b0;
    n = 0;
    while (!out_valid && n < 6) begin tick(); n++; end
    chk("coincide_drain", out_valid, 1);
    done = 1'b0;

    // Backpressure drain with ready pattern 1,0,0,1 and a stray strobe.
    pat = 4'b1001;
    prev_stall = 1'b0; prev_d = '0; prev_i = '0; prev_j = '0;
    for (int c = 0; c < 80; c++) begin
      if (out_done) break;
      out_ready = pat[3 - (c % 4)];
      z_stb = (c == 2);
      if (c == 3) begin
        chk("drain_stb_ack", z_ack, 0);
        chk("drain_stb_err", err, 1);
      end
      if (prev_stall) begin
        chk("stall_data", out_data, prev_d);
        chk("stall_idx", {out_i, out_j}, {prev_i, prev_j});
      end
      prev_stall = out_valid && !out_ready;
      prev_d = out_data; prev_i = out_i; prev_j = out_j;
      tick();
    end
    z_stb = 1'b0;
    wait_done(4);

    // Reset mid-drain after 5 transfers.
    out_ready = 1'b0;
    do_start();
    chk("restart2_err", err, 0);
    write_elem(1, 1, 32'h55);
    push_drain();
    xfer_cnt = 0;
    done = 1'b1; out_ready = 1'b1;
    tick();
    done = 1'b0;
    n = 0;
    while (xfer_cnt < 5 && n < 20) begin tick(); n++; end
    out_ready = 1'b0;
    chk("mid_count", xfer_cnt, 5);
    chk("mid_idx", {out_i, out_j}, 4'b0101);
    chk("mid_data", out_data, 32'h55);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    chk("midrst_valid", out_valid, 0);
    chk("midrst_done", out_done, 0);
    chk("midrst_err", err, 0);
    chk("midrst_idx", {out_i, out_j}, 0);
    nz = 0;
    for (int r = 0; r < M; r++)
      for (int c = 0; c < M; c++) begin
        z_i = ML'(r); z_j = ML'(c);
        #1;
        if (current_element !== '0) nz++;
      end
    chk("midrst_mem_nonzero", nz, 0);

    // Normal collection after the reset.
    do_start();
    write_elem(3, 3, 32'h77);
    write_elem(0, 1, 32'h11);
    push_drain();
    xfer_cnt = 0;
    done = 1'b1; out_ready = 1'b1;
    tick();
    chk("post_rst_valid", out_valid, 1);
    done = 1'b0;
    wait_done(40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/result_matrix_collector.md
Name: result_matrix_collector

Overview:
Downstream stage of sequential_matrix_multiplier. It owns the m×m result matrix and accepts (z_i, z_j, z_out) writes over the z_stb/z_ack handshake. It serves the current_element readback the multiplier uses for accumulation. Once the multiplier signals done, it drains the matrix row-major over a valid/ready stream for the output writer.

Parameters:
m, 4, matrix dimension (m×m results)
m_len, $clog2(m), index width
W, 32, element width (opaque bit pattern, never interpreted)

Ports:
clk  in  1  clock, all state changes on rising edge
rst  in  1  synchronous active-high reset
start  in  1  level; begins a new collection (honoured only in IDLE/FINISHED)
z_out  in  W  result value from multiplier
z_i  in  m_len  result row
z_j  in  m_len  result column
z_stb  in  1  result write strobe (held until acked)
z_ack  out  1  one-cycle write acknowledge
current_element  out  W  combinational read of mem[z_i][z_j]
done  in  1  multiplier finished
out_data  out  W  drained element
out_i  out  m_len  row of out_data
out_j  out  m_len  column of out_data
out_valid  out  1  out_data valid
out_ready  in  1  consumer accepts
out_last  out  1  high with element (m-1,m-1)
out_done  out  1  drain complete, held until next start
err  out  1  sticky: write to out-of-range index or write outside COLLECT

Behaviour:
- Reset (rst=1 at posedge): state=IDLE; all mem entries=0; z_ack, out_valid, out_last, out_done, err=0; out_i=out_j=0. Reset overrides any activity, including mid-drain or with a pending ack.
- States: IDLE, CLEAR, COLLECT, DRAIN, FINISHED.
- IDLE/FINISHED: start=1 -> CLEAR.
  - CLEAR lasts exactly 1 cycle. It zeroes all mem entries, clears err and out_done, and zeroes the drain counter.
  - Then -> COLLECT. start held high afterwards is ignored until FINISHED.
- COLLECT write rule:
  - Accept when z_stb=1 and z_ack=0.
  - mem[z_i][z_j] <= z_out and z_ack <= 1 on that edge.
  - z_ack always drops the following cycle, so a strobe held high is written at most once per 2 cycles.
  - The multiplier deasserts z_stb on seeing z_ack.
- Out-of-range index (z_i>=m or z_j>=m, possible only when m is not a power of 2): no write, still acked, err <= 1.
- current_element: combinational from mem at (z_i, z_j). A write becomes visible the cycle after its edge; there is no bypass.
- COLLECT -> DRAIN when done=1, z_stb=0 and z_ack=0.
  - If done and an unacked z_stb coincide, the write is accepted first and the transition happens on a later cycle.
- DRAIN:
  - out_valid=1; out_data=mem[out_i][out_j]; out_last=(out_i==m-1 && out_j==m-1).
  - On out_valid && out_ready: advance row-major (j increments and wraps to 0 with i+1).
  - out_data/out_i/out_j are stable while out_valid && !out_ready.
  - After the last transfer: out_valid=0, out_done=1, state=FINISHED.
- z_stb outside COLLECT: ignored (no write, z_ack stays 0), err <= 1.
- done outside COLLECT: ignored.
- Latency: first out_valid 1 cycle after leaving COLLECT. Full drain takes m*m cycles with out_ready held high.

Test Plan:
- Reset then start: after CLEAR, issue 16 writes (m=4) with mem[i][j]=i*4+j+1. Each z_ack is a single-cycle pulse. Assert done. Drain yields values 1..16 in row-major order with correct out_i/out_j, out_last only on 16, out_done=1 afterwards.
- Accumulate readback: write 0x3F800000 to (2,1). On the next cycle with z_i=2, z_j=1, current_element=0x3F800000. Overwrite with 0x40000000; readback updates the cycle after the ack.
- Held strobe: hold z_stb high for 6 cycles on (0,0). z_ack pattern is 1,0,1,0,1,0. The final mem value equals z_out from the last acked edge.
- Backpressure: during drain, toggle out_ready 1,0,0,1. out_data holds its value while stalled, no element is skipped or duplicated, and the transfer count is exactly 16.
- Corner events: done in the same cycle as an unacked z_stb -> the write lands, then DRAIN. z_stb during DRAIN -> no ack and err=1. A second start in FINISHED clears mem to 0 and err to 0.
- Reset mid-drain after 5 transfers: out_valid=0, state IDLE, all mem=0, out_done=0. A following start and collection behave normally.
